// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU-side memory responder.
// Accepts a single request from the CPU sequencer (en_mem) and carries it out
// on a 16-bit word-addressed bus with a req/ack handshake. Byte, aligned word
// and misaligned word accesses are supported; a misaligned word access is
// split into two bus phases (little-endian). Each phase has a wait limit,
// after which the access is abandoned and flagged with mem_err.
module mem_bus_ctrl #(
  parameter int unsigned  TIMEOUT  = 255,
  parameter logic [15:0]  ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_mem,
  input  logic        mem_we,
  input  logic        mem_byte,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        mem_wait,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [14:0] bus_addr,
  output logic [1:0]  bus_be,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter compares against TIMEOUT-1 because the cycle in which the
  // counter reads zero is already the first waiting cycle of the phase.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        lat_byte;
  logic        lat_odd;

  // A misaligned word access is the only case that needs a second phase.
  logic        split_access;
  assign split_access = !lat_byte && lat_odd;

  // Sequencer, bus drive and read-data capture, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      lat_byte  <= 1'b0;
      lat_odd   <= 1'b0;
      data_out  <= 16'h0000;
      mem_wait  <= 1'b0;
      mem_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 15'h0000;
      bus_be    <= 2'b00;
      bus_wdata <= 16'h0000;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (en_mem) begin
            state    <= PH1;
            wait_cnt <= 8'd0;
            lat_byte <= mem_byte;
            lat_odd  <= addr[0];
            mem_wait <= 1'b1;
            bus_req  <= 1'b1;
            bus_we   <= mem_we;
            bus_addr <= addr[15:1];
            if (mem_byte) begin
              bus_be    <= addr[0] ? 2'b10 : 2'b01;
              bus_wdata <= {data_in[7:0], data_in[7:0]};
            end else if (!addr[0]) begin
              bus_be    <= 2'b11;
              bus_wdata <= data_in;
            end else begin
              // Byte-swapped so PH1 sends the low byte on the odd lane and
              // PH2 sends the high byte on the even lane without reloading.
              bus_be    <= 2'b10;
              bus_wdata <= {data_in[7:0], data_in[15:8]};
            end
          end
        end

        PH1, PH2: begin
          if (bus_ack) begin
            if (!bus_we) begin
              if (lat_byte) begin
                data_out <= {8'h00, (lat_odd ? bus_rdata[15:8] : bus_rdata[7:0])};
              end else if (!lat_odd) begin
                data_out <= bus_rdata;
              end else if (state == PH1) begin
                data_out[7:0] <= bus_rdata[15:8];
              end else begin
                data_out[15:8] <= bus_rdata[7:0];
              end
            end
            if (state == PH1 && split_access) begin
              state    <= PH2;
              wait_cnt <= 8'd0;
              bus_addr <= bus_addr + 15'd1;
              bus_be   <= 2'b01;
            end else begin
              state    <= DONE;
              wait_cnt <= 8'd0;
              mem_wait <= 1'b0;
              bus_req  <= 1'b0;
              bus_we   <= 1'b0;
              bus_be   <= 2'b00;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state    <= DONE;
            wait_cnt <= 8'd0;
            mem_wait <= 1'b0;
            mem_err  <= 1'b1;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            bus_be   <= 2'b00;
            if (!bus_we) begin
              data_out <= ERR_DATA;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for mem_bus_ctrl.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en_mem;
  logic        mem_we;
  logic        mem_byte;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        mem_wait;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [14:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;

  int checks;
  int errors;

  mem_bus_ctrl #(
    .TIMEOUT  (4),
    .ERR_DATA (16'hFFFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_mem    (en_mem),
    .mem_we    (mem_we),
    .mem_byte  (mem_byte),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .mem_wait  (mem_wait),
    .mem_err   (mem_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns in the first PH1 cycle.
  task automatic start_access(input logic we, input logic byt,
                              input logic [15:0] a, input logic [15:0] d);
    en_mem   = 1'b1;
    mem_we   = we;
    mem_byte = byt;
    addr     = a;
    data_in  = d;
    tick();
    en_mem   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (data_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 0000", data_out); end
    checks++;
    if ({mem_wait, mem_err, bus_req, bus_we} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {mem_wait, mem_err, bus_req, bus_we}); end
    checks++;
    if ({bus_addr, bus_be, bus_wdata} !== 33'd0) begin errors++; $display("[TB] FAIL reset_bus: got %h/%b/%h expected zeros", bus_addr, bus_be, bus_wdata); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_aligned_read();
    int wait_cycles;
    wait_cycles = 0;
    start_access(1'b0, 1'b0, 16'h1234, 16'h0000);
    checks++;
    if (bus_addr !== 15'h091A || bus_be !== 2'b11 || bus_req !== 1'b1 || bus_we !== 1'b0) begin
      errors++; $display("[TB] FAIL aligned_setup: got addr=%h be=%b req=%b we=%b expected 091a/11/1/0", bus_addr, bus_be, bus_req, bus_we);
    end
    if (mem_wait) wait_cycles++;
    tick();
    if (mem_wait) wait_cycles++;
    tick();
    if (mem_wait) wait_cycles++;
    bus_ack   = 1'b1;
    bus_rdata = 16'hBEEF;
    tick();
    bus_ack   = 1'b0;
    if (mem_wait) wait_cycles++;
    checks++;
    if (wait_cycles != 3) begin errors++; $display("[TB] FAIL aligned_wait_len: got %0d expected 3", wait_cycles); end
    checks++;
    if (data_out !== 16'hBEEF) begin errors++; $display("[TB] FAIL aligned_data: got %h expected beef", data_out); end
    checks++;
    if (bus_req !== 1'b0 || mem_err !== 1'b0) begin errors++; $display("[TB] FAIL aligned_done: got req=%b err=%b expected 0/0", bus_req, mem_err); end
    tick();
  endtask

  task automatic test_byte_write();
    start_access(1'b1, 1'b1, 16'h0101, 16'h00A5);
    bus_ack = 1'b1;
    checks++;
    if (bus_addr !== 15'h0080 || bus_be !== 2'b10 || bus_we !== 1'b1) begin
      errors++; $display("[TB] FAIL bytew_setup: got addr=%h be=%b we=%b expected 0080/10/1", bus_addr, bus_be, bus_we);
    end
    checks++;
    if (bus_wdata !== 16'hA5A5) begin errors++; $display("[TB] FAIL bytew_wdata: got %h expected a5a5", bus_wdata); end
    tick();
    bus_ack = 1'b0;
    checks++;
    if (data_out !== 16'hBEEF || mem_wait !== 1'b0) begin errors++; $display("[TB] FAIL bytew_done: got data=%h wait=%b expected beef/0", data_out, mem_wait); end
    tick();
  endtask

  task automatic test_misaligned_read();
    start_access(1'b0, 1'b0, 16'h2001, 16'h0000);
    checks++;
    if (bus_addr !== 15'h1000 || bus_be !== 2'b10) begin errors++; $display("[TB] FAIL misr_ph1: got addr=%h be=%b expected 1000/10", bus_addr, bus_be); end
    bus_ack   = 1'b1;
    bus_rdata = 16'h34AB;
    tick();
    bus_rdata = 16'hCD12;
    checks++;
    if (bus_addr !== 15'h1001 || bus_be !== 2'b01 || bus_req !== 1'b1 || mem_wait !== 1'b1) begin
      errors++; $display("[TB] FAIL misr_ph2: got addr=%h be=%b req=%b wait=%b expected 1001/01/1/1", bus_addr, bus_be, bus_req, mem_wait);
    end
    tick();
    bus_ack = 1'b0;
    checks++;
    if (data_out !== 16'h1234) begin errors++; $display("[TB] FAIL misr_data: got %h expected 1234", data_out); end
    tick();
  endtask

  task automatic test_wrap_write();
    start_access(1'b1, 1'b0, 16'hFFFF, 16'hCAFE);
    checks++;
    if (bus_addr !== 15'h7FFF || bus_be !== 2'b10 || bus_wdata[15:8] !== 8'hFE || bus_we !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_ph1: got addr=%h be=%b lane=%h we=%b expected 7fff/10/fe/1", bus_addr, bus_be, bus_wdata[15:8], bus_we);
    end
    bus_ack = 1'b1;
    tick();
    checks++;
    if (bus_addr !== 15'h0000 || bus_be !== 2'b01 || bus_wdata[7:0] !== 8'hCA) begin
      errors++; $display("[TB] FAIL wrap_ph2: got addr=%h be=%b lane=%h expected 0000/01/ca", bus_addr, bus_be, bus_wdata[7:0]);
    end
    tick();
    bus_ack = 1'b0;
    checks++;
    if (data_out !== 16'h1234 || mem_err !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_done: got data=%h err=%b req=%b expected 1234/0/0", data_out, mem_err, bus_req);
    end
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    start_access(1'b0, 1'b0, 16'h0040, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      if (!bus_req) break;
      req_cycles++;
      tick();
    end
    checks++;
    if (req_cycles != 4) begin errors++; $display("[TB] FAIL timeout_len: got %0d expected 4", req_cycles); end
    checks++;
    if (mem_err !== 1'b1 || mem_wait !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err: got err=%b wait=%b expected 1/0", mem_err, mem_wait); end
    checks++;
    if (data_out !== 16'hFFFF) begin errors++; $display("[TB] FAIL timeout_data: got %h expected ffff", data_out); end
    tick();
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse: got %b expected 0", mem_err); end
  endtask

  task automatic test_back_to_back();
    start_access(1'b0, 1'b0, 16'h0200, 16'h0000);
    bus_ack   = 1'b1;
    bus_rdata = 16'h1111;
    tick();
    bus_ack   = 1'b0;
    // Now in DONE: a request here must wait for the following IDLE cycle.
    en_mem   = 1'b1;
    mem_we   = 1'b0;
    mem_byte = 1'b1;
    addr     = 16'h0301;
    tick();
    checks++;
    if (bus_req !== 1'b0 || mem_wait !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_ignored: got req=%b wait=%b expected 0/0", bus_req, mem_wait); end
    tick();
    en_mem = 1'b0;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 15'h0180 || bus_be !== 2'b10) begin
      errors++; $display("[TB] FAIL b2b_accept: got req=%b addr=%h be=%b expected 1/0180/10", bus_req, bus_addr, bus_be);
    end
    bus_ack   = 1'b1;
    bus_rdata = 16'h22AB;
    tick();
    bus_ack   = 1'b0;
    checks++;
    if (data_out !== 16'h0022) begin errors++; $display("[TB] FAIL b2b_byte_read: got %h expected 0022", data_out); end
    tick();
  endtask

  task automatic test_stray_ack();
    bus_ack   = 1'b1;
    bus_rdata = 16'h9999;
    tick();
    tick();
    bus_ack   = 1'b0;
    checks++;
    if (data_out !== 16'h0022 || bus_req !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("[TB] FAIL stray_ack: got data=%h req=%b err=%b expected 0022/0/0", data_out, bus_req, mem_err);
    end
  endtask

  task automatic test_reset_mid_access();
    start_access(1'b0, 1'b0, 16'h3003, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || mem_wait !== 1'b0 || mem_err !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_flags: got req=%b wait=%b err=%b expected 0/0/0", bus_req, mem_wait, mem_err);
    end
    checks++;
    if (data_out !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 0000", data_out); end
    tick();
    rst_n = 1'b1;
    tick();
    start_access(1'b0, 1'b0, 16'h0010, 16'h0000);
    checks++;
    if (bus_addr !== 15'h0008 || bus_be !== 2'b11) begin errors++; $display("[TB] FAIL midrst_setup: got addr=%h be=%b expected 0008/11", bus_addr, bus_be); end
    bus_ack   = 1'b1;
    bus_rdata = 16'h5A5A;
    tick();
    bus_ack   = 1'b0;
    checks++;
    if (data_out !== 16'h5A5A || mem_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_recover: got data=%h err=%b expected 5a5a/0", data_out, mem_err); end
    tick();
  endtask

  // Test sequence.
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    en_mem    = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    addr      = 16'h0000;
    data_in   = 16'h0000;
    bus_rdata = 16'h0000;
    bus_ack   = 1'b0;
    test_reset();
    test_aligned_read();
    test_byte_write();
    test_misaligned_read();
    test_wrap_write();
    test_timeout();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
